// File: rtl/param_assoc_dcache.sv
// Write-back, write-allocate set-associative data cache (1 or 2 ways, LRU)
// sitting between a single-cycle core and a variable-latency line memory.
module param_assoc_dcache #(
    parameter int ADDR_W      = 12,
    parameter int SETS        = 4,
    parameter int BLOCK_WORDS = 4,
    parameter int WAYS        = 2,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [32*BLOCK_WORDS-1:0] mem_wdata,
    input  logic [32*BLOCK_WORDS-1:0] mem_rdata,
    input  logic                     mem_ready,
    output logic [CNT_W-1:0]         hit_count,
    output logic [CNT_W-1:0]         miss_count
);

    localparam int WORD_BITS = $clog2(BLOCK_WORDS);
    localparam int WI_W      = (WORD_BITS > 0) ? WORD_BITS : 1;
    localparam int SET_BITS  = $clog2(SETS);
    localparam int OFF       = 2 + WORD_BITS;
    localparam int TAG_W     = ADDR_W - OFF - SET_BITS;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    state_t state_reg, state_next;

    logic [WI_W-1:0]     word_idx;
    logic [SET_BITS-1:0] set_idx;
    logic [TAG_W-1:0]    req_tag;

    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [31:0]      data_mem [WAYS][SETS][BLOCK_WORDS];

    logic [WAYS-1:0][SETS-1:0] valid_reg;
    logic [WAYS-1:0][SETS-1:0] dirty_reg;
    logic [SETS-1:0]           lru_reg;

    logic                victim_way_reg;
    logic [SET_BITS-1:0] set_reg;
    logic [TAG_W-1:0]    tag_reg;
    logic [TAG_W-1:0]    victim_tag_reg;
    logic                reissue_reg;

    logic [WAYS-1:0] hit_vec;
    logic            hit;
    logic            hit_way;
    logic            victim_way;
    logic            victim_dirty;
    logic            req;

    assign word_idx = WI_W'((addr >> 2) & ADDR_W'(BLOCK_WORDS - 1));
    assign set_idx  = SET_BITS'(addr >> OFF);
    assign req_tag  = TAG_W'(addr >> (OFF + SET_BITS));
    assign req      = mem_read | mem_write;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_hit
            assign hit_vec[gi] = valid_reg[gi][set_idx] && (tag_mem[gi][set_idx] == req_tag);
        end
    endgenerate

    assign hit     = |hit_vec;
    assign hit_way = (WAYS == 2) ? hit_vec[WAYS-1] : 1'b0;
    assign rdata   = hit ? data_mem[hit_way][set_idx][word_idx] : 32'h0;

    // Invalid ways are filled first (way 0 before way 1), then the LRU way.
    always_comb begin
        victim_way = 1'b0;
        if (WAYS == 2 && valid_reg[0][set_idx])
            victim_way = valid_reg[WAYS-1][set_idx] ? lru_reg[set_idx] : 1'b1;
    end

    assign victim_dirty = valid_reg[victim_way][set_idx] & dirty_reg[victim_way][set_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req && !hit) state_next = victim_dirty ? WB : FILL;
            WB:      if (mem_ready) state_next = FILL;
            FILL:    if (mem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        case (state_reg)
            IDLE: stall = req & ~hit;
            WB: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {victim_tag_reg, set_reg, {OFF{1'b0}}};
            end
            FILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {tag_reg, set_reg, {OFF{1'b0}}};
            end
            default: ;
        endcase
        // While reset is held the core must not be frozen by a stale request.
        if (!rst)
            stall = 1'b0;
    end

    generate
        for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_wb_data
            assign mem_wdata[32*gi +: 32] = (state_reg == WB) ?
                                            data_mem[victim_way_reg][set_reg][gi] : 32'h0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg      <= '0;
            dirty_reg      <= '0;
            lru_reg        <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
            victim_way_reg <= 1'b0;
            set_reg        <= '0;
            tag_reg        <= '0;
            victim_tag_reg <= '0;
            reissue_reg    <= 1'b0;
        end else begin
            reissue_reg <= 1'b0;
            case (state_reg)
                IDLE: if (req) begin
                    if (hit) begin
                        if (WAYS == 2)
                            lru_reg[set_idx] <= ~hit_way;
                        if (mem_write)
                            dirty_reg[hit_way][set_idx] <= 1'b1;
                        // The replayed access after a fill was already counted as a miss.
                        if (!reissue_reg && hit_count != '1)
                            hit_count <= hit_count + CNT_W'(1);
                    end else begin
                        if (miss_count != '1)
                            miss_count <= miss_count + CNT_W'(1);
                        victim_way_reg <= victim_way;
                        set_reg        <= set_idx;
                        tag_reg        <= req_tag;
                        victim_tag_reg <= tag_mem[victim_way][set_idx];
                    end
                end
                WB: if (mem_ready)
                    dirty_reg[victim_way_reg][set_reg] <= 1'b0;
                FILL: if (mem_ready) begin
                    valid_reg[victim_way_reg][set_reg] <= 1'b1;
                    dirty_reg[victim_way_reg][set_reg] <= 1'b0;
                    reissue_reg                        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays hold no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (rst && state_reg == IDLE && mem_write && hit)
            data_mem[hit_way][set_idx][word_idx] <= wdata;
        if (rst && state_reg == FILL && mem_ready) begin
            tag_mem[victim_way_reg][set_reg] <= tag_reg;
            for (int w = 0; w < BLOCK_WORDS; w++)
                data_mem[victim_way_reg][set_reg][w] <= mem_rdata[32*w +: 32];
        end
    end

endmodule

// File: tb/tb_param_assoc_dcache.sv
// Scoreboard bench for param_assoc_dcache: directed core accesses against a
// latency-programmable line memory model, checked by decoupled monitors.
module tb_param_assoc_dcache;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [11:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [11:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready = 1'b0;
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;

    param_assoc_dcache #(
        .ADDR_W(12), .SETS(4), .BLOCK_WORDS(4), .WAYS(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [11:0]  addr;
        logic [127:0] data;
    } mem_txn_t;

    mem_txn_t    exp_mem_q[$];
    logic [31:0] exp_rd_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 0;

    logic [31:0] bmem [1024];

    int st_stalls, st_fills, st_wbs, st_reqs, st_unstable;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always_comb begin
        mem_rdata = '0;
        for (int k = 0; k < 4; k++)
            mem_rdata[32*k +: 32] = bmem[((int'(mem_addr) >> 2) + k) % 1024];
    end

    // Memory side: answers after 'lat' not-ready cycles, then checks each completed transfer.
    initial begin
        logic         pend_valid;
        logic         pw;
        logic [11:0]  pa;
        logic [127:0] pd;
        int           cnt;
        mem_txn_t     em;
        pend_valid = 1'b0;
        pw = 1'b0; pa = '0; pd = '0; cnt = 0;
        for (int i = 0; i < 1024; i++)
            bmem[i] = 32'hA000_0000 | 32'(i);
        bmem[16] = 32'h11; bmem[17] = 32'h22; bmem[18] = 32'h33; bmem[19] = 32'h44;
        forever begin
            @(negedge clk);
            if (pend_valid) begin
                pend_valid = 1'b0;
                if (exp_mem_q.size() == 0) begin
                    check("mem_txn_unexpected", {pw, 4'h0, pa}, '1);
                end else begin
                    em = exp_mem_q.pop_front();
                    check("mem_we", 128'(pw), 128'(em.we));
                    check("mem_addr", 128'(pa), 128'(em.addr));
                    if (em.we)
                        check("mem_wdata", pd, em.data);
                end
                if (pw)
                    for (int k = 0; k < 4; k++)
                        bmem[(int'(pa) >> 2) + k] = pd[32*k +: 32];
            end
            if (rst && mem_req) begin
                if (cnt >= lat) begin
                    mem_ready  = 1'b1;
                    pend_valid = 1'b1;
                    pw = mem_we; pa = mem_addr; pd = mem_wdata;
                    cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Core side: every load that completes (request held, stall low) is checked.
    always @(negedge clk) begin
        if (rst && mem_read && !mem_write && !stall) begin
            if (exp_rd_q.size() == 0)
                check("rdata_unexpected", 128'(rdata), '1);
            else
                check("rdata", 128'(rdata), 128'(exp_rd_q.pop_front()));
        end
    end

    task automatic access(input logic wr, input logic [11:0] a, input logic [31:0] wd);
        bit           done = 0;
        logic [141:0] first = '0;
        logic [141:0] cur;
        bit           have_first = 0;
        st_stalls = 0; st_fills = 0; st_wbs = 0; st_reqs = 0; st_unstable = 0;
        mem_read  = !wr;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (mem_req) begin
                st_reqs++;
                if (mem_we) begin
                    st_wbs++;
                    cur = {stall, mem_req, mem_we, mem_addr, mem_wdata};
                    if (!have_first) begin
                        first = cur;
                        have_first = 1;
                    end else if (cur !== first) begin
                        st_unstable++;
                    end
                end else if (mem_addr == (a & 12'hFF0)) begin
                    st_fills++;
                end
            end
            if (!stall) begin
                done = 1;
                break;
            end
            st_stalls++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL access_timeout: addr %03h still stalled, expected completion", a);
        end
        $display("[TB] %s %03h stalls=%0d wb_cycles=%0d fill_cycles=%0d",
                 wr ? "write" : "read ", a, st_stalls, st_wbs, st_fills);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_stall", 128'(stall), 128'(0));
        check("reset_mem_req", 128'(mem_req), 128'(0));
        check("reset_mem_we", 128'(mem_we), 128'(0));
        check("reset_mem_addr", 128'(mem_addr), 128'(0));
        check("reset_rdata", 128'(rdata), 128'(0));
        check("reset_hit_count", 128'(hit_count), 128'(0));
        check("reset_miss_count", 128'(miss_count), 128'(0));
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Cold read miss with 3 not-ready cycles
        lat = 3;
        exp_mem_q.push_back('{we: 1'b0, addr: 12'h040, data: '0});
        exp_rd_q.push_back(32'h11);
        access(1'b0, 12'h040, 32'h0);
        check("cold_stall_cycles", 128'(st_stalls), 128'(5));
        check("cold_fill_cycles", 128'(st_fills), 128'(4));
        check("cold_miss_count", 128'(miss_count), 128'(1));
        check("cold_hit_count", 128'(hit_count), 128'(0));

        // Hit, store, reload
        lat = 1;
        exp_rd_q.push_back(32'h22);
        access(1'b0, 12'h044, 32'h0);
        check("hit_stall_cycles", 128'(st_stalls), 128'(0));
        check("hit_count_1", 128'(hit_count), 128'(1));
        access(1'b1, 12'h048, 32'hDEADBEEF);
        check("store_stall_cycles", 128'(st_stalls), 128'(0));
        check("store_mem_req_cycles", 128'(st_reqs), 128'(0));
        exp_rd_q.push_back(32'hDEADBEEF);
        access(1'b0, 12'h048, 32'h0);
        check("reload_stall_cycles", 128'(st_stalls), 128'(0));

        // Dirty eviction through LRU
        exp_mem_q.push_back('{we: 1'b0, addr: 12'h080, data: '0});
        exp_rd_q.push_back(32'hA000_0020);
        access(1'b0, 12'h080, 32'h0);
        check("fill_way1_wb_cycles", 128'(st_wbs), 128'(0));
        exp_mem_q.push_back('{we: 1'b1, addr: 12'h040,
                              data: 128'h00000044_DEADBEEF_00000022_00000011});
        exp_mem_q.push_back('{we: 1'b0, addr: 12'h0C0, data: '0});
        exp_rd_q.push_back(32'hA000_0030);
        access(1'b0, 12'h0C0, 32'h0);
        check("dirty_evict_wb_cycles", 128'(st_wbs), 128'(2));
        check("dirty_evict_miss_count", 128'(miss_count), 128'(3));

        // Clean eviction of way 1
        exp_mem_q.push_back('{we: 1'b0, addr: 12'h040, data: '0});
        exp_rd_q.push_back(32'h11);
        access(1'b0, 12'h040, 32'h0);
        check("clean_evict_wb_cycles", 128'(st_wbs), 128'(0));
        check("clean_evict_fill_cycles", 128'(st_fills), 128'(2));
        exp_rd_q.push_back(32'hDEADBEEF);
        access(1'b0, 12'h048, 32'h0);
        check("written_back_word_stall", 128'(st_stalls), 128'(0));
        check("clean_evict_miss_count", 128'(miss_count), 128'(4));

        // Long write-back latency
        access(1'b1, 12'h0C4, 32'h55);
        exp_rd_q.push_back(32'h11);
        access(1'b0, 12'h040, 32'h0);
        lat = 100;
        exp_mem_q.push_back('{we: 1'b1, addr: 12'h0C0,
                              data: 128'hA0000033_A0000032_00000055_A0000030});
        exp_mem_q.push_back('{we: 1'b0, addr: 12'h100, data: '0});
        exp_rd_q.push_back(32'hA000_0040);
        access(1'b0, 12'h100, 32'h0);
        check("long_wb_cycles", 128'(st_wbs), 128'(101));
        check("long_wb_unstable", 128'(st_unstable), 128'(0));
        check("long_stall_cycles", 128'(st_stalls), 128'(203));
        check("long_hit_count", 128'(hit_count), 128'(6));
        check("long_miss_count", 128'(miss_count), 128'(5));

        // Reset in the middle of a fill
        mem_read = 1'b1;
        addr     = 12'h140;
        waited   = 0;
        while (!mem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("rst_fill_started", 128'(mem_req), 128'(1));
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_mem_req", 128'(mem_req), 128'(0));
        check("rst_mid_stall", 128'(stall), 128'(0));
        mem_read = 1'b0;
        #1;
        check("rst_mid_hit_count", 128'(hit_count), 128'(0));
        check("rst_mid_miss_count", 128'(miss_count), 128'(0));
        check("rst_mid_rdata", 128'(rdata), 128'(0));
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        lat = 2;
        exp_mem_q.push_back('{we: 1'b0, addr: 12'h040, data: '0});
        exp_rd_q.push_back(32'h11);
        access(1'b0, 12'h040, 32'h0);
        check("post_rst_stall_cycles", 128'(st_stalls), 128'(4));
        check("post_rst_miss_count", 128'(miss_count), 128'(1));
        check("post_rst_hit_count", 128'(hit_count), 128'(0));

        repeat (2) @(negedge clk);
        check("mem_queue_drained", 128'(exp_mem_q.size()), 128'(0));
        check("rd_queue_drained", 128'(exp_rd_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
